one_unit_w_update: RTL and testbench

// - Consumes the per-sample (zTw)^3 and (zTw)^2 streams from the cube stage and evaluates the FastICA one-unit fixed-point update
//   w_new[k] = mean(z[k]*(zTw)^3) - 3*mean((zTw)^2)*w[k], for k = 1..4.
// - Accumulates over N samples, then finalises the 4 components serially and presents w_new to the normalisation stage.
// - All data is signed Q13 in 26 bits: 1.0 = 8192.

---
 rtl/ica_fix_pkg.sv | 12 +
 rtl/w_upd_mac.sv | 26 ++
 rtl/one_unit_w_update.sv | 124 ++++++++++++
 tb/tb_one_unit_w_update.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ica_fix_pkg.sv
// ica_fix_pkg: Q13 fixed-point constants, saturation helper and update-FSM states
package ica_fix_pkg;
    localparam int W = 26;
    localparam int FRAC = 13;
    localparam logic signed [W-1:0] Q_ONE = 26'sd8192;
    localparam logic signed [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;
    function automatic logic signed [W-1:0] sat26(input logic signed [127:0] x);
        return x > 128'(Q_MAX) ? Q_MAX : x < 128'(Q_MIN) ? Q_MIN : x[W-1:0];
    endfunction
endpackage

// File: rtl/w_upd_mac.sv
// w_upd_mac: per-component z*y3 product accumulator used during the accumulation phase
module w_upd_mac #(
    parameter int W = 26,
    parameter int LOG2N = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [W-1:0]         z,
    input  logic signed [W-1:0]         y3,
    output logic signed [2*W+LOG2N-1:0] acc
);
    localparam int AW = 2*W + LOG2N;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [2*W-1:0] prod;
    always_comb begin
        prod = (2*W)'(z) * (2*W)'(y3);
        acc_d = clr ? '0 : en ? acc_q + AW'(prod) : acc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else acc_q <= acc_d;
    end
    assign acc = acc_q;
endmodule

// File: rtl/one_unit_w_update.sv
// one_unit_w_update: FastICA one-unit update, accumulates N samples then finalises w_new serially
module one_unit_w_update import ica_fix_pkg::*; #(
    parameter int LOG2N = 10,
    parameter int W = 26,
    parameter int FRAC = 13
) (
    input  logic                clk_upd,
    input  logic                rst_upd,
    input  logic                start,
    input  logic signed [W-1:0] w_in1,
    input  logic signed [W-1:0] w_in2,
    input  logic signed [W-1:0] w_in3,
    input  logic signed [W-1:0] w_in4,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] z1,
    input  logic signed [W-1:0] z2,
    input  logic signed [W-1:0] z3,
    input  logic signed [W-1:0] z4,
    input  logic signed [W-1:0] y3,
    input  logic signed [W-1:0] y2,
    output logic signed [W-1:0] w_out1,
    output logic signed [W-1:0] w_out2,
    output logic signed [W-1:0] w_out3,
    output logic signed [W-1:0] w_out4,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    localparam int AW = 2*W + LOG2N;
    localparam int GW = W + LOG2N;
    state_t state_q, state_d;
    logic [LOG2N-1:0] count_q, count_d;
    logic [1:0] k_q, k_d;
    logic signed [GW-1:0] acc_g2_q, acc_g2_d;
    logic signed [W-1:0] w_q [4];
    logic signed [W-1:0] w_d [4];
    logic signed [W-1:0] w_out_q [4];
    logic signed [W-1:0] w_out_d [4];
    logic out_valid_q, out_valid_d;
    logic signed [AW-1:0] acc_zg [4];
    logic signed [W-1:0] z_v [4];
    logic signed [W-1:0] m_g2;
    logic signed [W+1:0] g3;
    logic signed [2*W+1:0] prod_f;
    logic signed [127:0] m_zg, t, diff;
    logic clr, acc_en, hs;
    assign z_v = '{z1, z2, z3, z4};
    assign acc_en = state_q == ACCUM && in_valid;
    for (genvar i = 0; i < 4; i++) begin : g_mac
        w_upd_mac #(.W(W), .LOG2N(LOG2N)) u_mac (
            .clk(clk_upd), .rst(rst_upd), .clr(clr), .en(acc_en),
            .z(z_v[i]), .y3(y3), .acc(acc_zg[i])
        );
    end
    always_comb begin
        m_g2 = W'(acc_g2_q >>> LOG2N);
        g3 = ((W+2)'(m_g2) <<< 1) + (W+2)'(m_g2);
        prod_f = (2*W+2)'(g3) * (2*W+2)'(w_q[k_q]);
        m_zg = 128'(acc_zg[k_q]) >>> (LOG2N + FRAC);
        t = 128'(prod_f) >>> FRAC;
        diff = m_zg - t;
        hs = out_valid_q && out_ready;
        state_d = state_q;
        count_d = count_q;
        k_d = k_q;
        acc_g2_d = acc_g2_q;
        w_d = w_q;
        w_out_d = w_out_q;
        out_valid_d = 1'b0;
        clr = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                w_d = '{w_in1, w_in2, w_in3, w_in4};
                count_d = '0;
                acc_g2_d = '0;
                clr = 1'b1;
            end
            ACCUM: if (in_valid) begin
                count_d = count_q + LOG2N'(1);
                acc_g2_d = acc_g2_q + GW'(y2);
                state_d = &count_q ? FINAL : ACCUM;
                k_d = '0;
            end
            FINAL: begin
                w_out_d[k_q] = sat26(diff);
                k_d = k_q + 2'd1;
                state_d = k_q == 2'd3 ? DONE : FINAL;
            end
            DONE: begin
                out_valid_d = !hs;
                state_d = hs ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_upd) begin
        if (rst_upd) begin
            state_q <= IDLE;
            count_q <= '0;
            k_q <= '0;
            acc_g2_q <= '0;
            w_q <= '{default: '0};
            w_out_q <= '{default: '0};
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            k_q <= k_d;
            acc_g2_q <= acc_g2_d;
            w_q <= w_d;
            w_out_q <= w_out_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign in_ready = state_q == ACCUM;
    assign busy = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign w_out1 = w_out_q[0];
    assign w_out2 = w_out_q[1];
    assign w_out3 = w_out_q[2];
    assign w_out4 = w_out_q[3];
endmodule

// File: tb/tb_one_unit_w_update.sv
// tb_one_unit_w_update: directed self-checking bench for the one-unit update with N = 4
module tb_one_unit_w_update;
    localparam logic signed [25:0] MAXV = 26'sd33554431;
    localparam logic signed [25:0] MINV = -26'sd33554431 - 26'sd1;
    logic clk_upd = 1'b0;
    logic rst_upd = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [25:0] w_in1 = '0, w_in2 = '0, w_in3 = '0, w_in4 = '0;
    logic signed [25:0] z1 = '0, z2 = '0, z3 = '0, z4 = '0, y3 = '0, y2 = '0;
    logic signed [25:0] w_out1, w_out2, w_out3, w_out4;
    logic in_ready, out_valid, busy;
    int n_assert = 0;
    int n_fail = 0;
    always #5 clk_upd = ~clk_upd;
    one_unit_w_update #(.LOG2N(2)) dut (
        .clk_upd(clk_upd), .rst_upd(rst_upd), .start(start),
        .w_in1(w_in1), .w_in2(w_in2), .w_in3(w_in3), .w_in4(w_in4),
        .in_valid(in_valid), .in_ready(in_ready),
        .z1(z1), .z2(z2), .z3(z3), .z4(z4), .y3(y3), .y2(y2),
        .w_out1(w_out1), .w_out2(w_out2), .w_out3(w_out3), .w_out4(w_out4),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic do_start(input logic signed [25:0] a, input logic signed [25:0] b, input logic signed [25:0] c, input logic signed [25:0] d);
        w_in1 = a; w_in2 = b; w_in3 = c; w_in4 = d;
        start = 1'b1;
        @(negedge clk_upd);
        start = 1'b0;
    endtask
    task automatic send(input logic signed [25:0] a, input logic signed [25:0] b, input logic signed [25:0] c, input logic signed [25:0] d, input logic signed [25:0] c3, input logic signed [25:0] c2);
        z1 = a; z2 = b; z3 = c; z4 = d; y3 = c3; y2 = c2;
        in_valid = 1'b1;
        @(negedge clk_upd);
        in_valid = 1'b0;
    endtask
    task automatic wait_out(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk_upd);
            lat++;
        end
        chk({tag, "_latency"}, lat, 5);
    endtask
    task automatic check_w(input string tag, input logic signed [25:0] a, input logic signed [25:0] b, input logic signed [25:0] c, input logic signed [25:0] d);
        chk({tag, "_w1"}, w_out1, a);
        chk({tag, "_w2"}, w_out2, b);
        chk({tag, "_w3"}, w_out3, c);
        chk({tag, "_w4"}, w_out4, d);
    endtask
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk_upd);
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, out_valid, 0);
        chk({tag, "_hs_busy"}, busy, 0);
    endtask
    task automatic run_t1(input string tag);
        do_start(26'sd8192, 0, 0, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready"}, in_ready, 1);
        repeat (4) send(26'sd8192, 0, 0, 0, 26'sd8192, 26'sd8192);
        wait_out(tag);
        check_w(tag, -26'sd16384, 0, 0, 0);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        handshake(tag);
    endtask
    initial begin
        repeat (2) @(negedge clk_upd);
        rst_upd = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        check_w("rst", 0, 0, 0, 0);
        send(26'sd8192, 26'sd8192, 0, 0, 26'sd8192, 26'sd8192);
        chk("idle_in_valid_busy", busy, 0);
        run_t1("t1");
        chk("t1_hold_idle", w_out1, -26'sd16384);
        do_start(0, 26'sd8192, 0, 0);
        repeat (4) send(-26'sd8192, 26'sd4096, 0, 0, 26'sd8192, 0);
        wait_out("t2");
        check_w("t2", -26'sd8192, 26'sd4096, 0, 0);
        handshake("t2");
        do_start(0, 0, 0, 0);
        repeat (4) send(MAXV, 0, 0, 0, MAXV, 0);
        wait_out("t3p");
        chk("t3p_w1", w_out1, MAXV);
        handshake("t3p");
        do_start(0, 0, 0, 0);
        repeat (4) send(MINV, 0, 0, 0, MAXV, 0);
        wait_out("t3n");
        chk("t3n_w1", w_out1, MINV);
        handshake("t3n");
        do_start(26'sd8192, 0, 0, 0);
        send(26'sd8192, 0, 0, 0, 26'sd8192, 26'sd8192);
        @(negedge clk_upd);
        do_start(0, 26'sd8192, 26'sd8192, 26'sd8192);
        chk("t4_start_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            send(26'sd8192, 0, 0, 0, 26'sd8192, 26'sd8192);
            if (i < 2) repeat (2) @(negedge clk_upd);
        end
        wait_out("t4");
        check_w("t4", -26'sd16384, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            start = 1'(i % 3 == 0);
            w_in1 = 26'sd4096;
            z1 = 26'sd8192; y3 = 26'sd8192; y2 = 26'sd8192;
            @(negedge clk_upd);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_w1", w_out1, -26'sd16384);
            chk("t4_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk_upd);
        start = 1'b0;
        out_ready = 1'b0;
        chk("t4_hs_busy", busy, 0);
        chk("t4_hs_valid", out_valid, 0);
        @(negedge clk_upd);
        chk("t4_hs_start_ignored", busy, 0);
        chk("t4_idle_hold_w1", w_out1, -26'sd16384);
        do_start(26'sd8192, 0, 0, 0);
        repeat (2) send(26'sd8192, 26'sd8192, 26'sd8192, 26'sd8192, 26'sd8192, 26'sd8192);
        rst_upd = 1'b1;
        @(negedge clk_upd);
        rst_upd = 1'b0;
        check_w("t5_rst", 0, 0, 0, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        run_t1("t5");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
